// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester the downstream FIFO for a
// whole packet (until its last word is written), then rotates priority.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            ack,
   input  logic                          full,
   output logic                          wr,
   output logic [DATA_WIDTH-1:0]         wr_data,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t              state, state_nxt;
   logic [ID_WIDTH-1:0] grant_nxt;
   logic [ID_WIDTH-1:0] rr_ptr, rr_nxt;
   logic [ID_WIDTH-1:0] pick_id, cand;
   logic                pick_valid;
   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
   end

   // Scan offsets from high to low so the lowest offset from rr_ptr wins;
   // NUM_REQ is a power of two, so the ID_WIDTH-bit add wraps for free.
   always_comb begin
      pick_valid = 1'b0;
      pick_id    = rr_ptr;
      cand       = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = rr_ptr + ID_WIDTH'(k);
         if (req[cand]) begin
            pick_valid = 1'b1;
            pick_id    = cand;
         end
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant_id;
      rr_nxt    = rr_ptr;
      wr        = 1'b0;
      ack       = '0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_nxt = LOCKED;
               grant_nxt = pick_id;
            end
         end
         LOCKED: begin
            wr            = req[grant_id] & ~full;
            ack[grant_id] = wr;
            if (wr && req_last[grant_id]) begin
               state_nxt = IDLE;
               rr_nxt    = grant_id + ID_WIDTH'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         grant_id <= grant_nxt;
         rr_ptr   <= rr_nxt;
      end
   end

   assign busy    = (state == LOCKED);
   assign wr_data = data_arr[grant_id];

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: inputs change just after the rising
// edge, outputs are checked at the falling edge against hand-derived values.
module tb_fifo_wr_arbiter;

   localparam int DW = 8;
   localparam int NR = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [NR-1:0] req;
   logic [NR-1:0] req_last;
   logic [DW-1:0] d [NR];
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0] ack;
   logic          full;
   logic          wr;
   logic [DW-1:0] wr_data;
   logic [1:0]    grant_id;
   logic          busy;

   int errors = 0;
   int checks = 0;

   assign req_data = {d[3], d[2], d[1], d[0]};

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_last (req_last),
      .req_data (req_data),
      .ack      (ack),
      .full     (full),
      .wr       (wr),
      .wr_data  (wr_data),
      .grant_id (grant_id),
      .busy     (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Check one cycle's outputs at the falling edge, then move past the next rising edge.
   task automatic cyc(input string tag, input logic exp_wr, input logic [3:0] exp_ack,
                      input logic [1:0] exp_gid, input logic exp_busy, input logic [7:0] exp_data);
      @(negedge clk);
      check({tag, ".wr"},   32'(wr),       32'(exp_wr));
      check({tag, ".ack"},  32'(ack),      32'(exp_ack));
      check({tag, ".gid"},  32'(grant_id), 32'(exp_gid));
      check({tag, ".busy"}, 32'(busy),     32'(exp_busy));
      if (exp_wr)
         check({tag, ".data"}, 32'(wr_data), 32'(exp_data));
      next_cycle();
   endtask

   int exp_order [5] = '{0, 1, 2, 3, 0};
   int prev_gid  [5] = '{3, 0, 1, 2, 3};

   initial begin
      reset = 1'b1; req = '0; req_last = '0; full = 1'b0;
      for (int i = 0; i < NR; i++) d[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc("reset", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);

      // Two requesters: 1 wins from rr_ptr=0, then 3 after 1's last.
      req = 4'b1010; d[1] = 8'h11; d[3] = 8'h31;
      cyc("a_idle", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);
      cyc("a_w0",   1'b1, 4'b0010, 2'd1, 1'b1, 8'h11);
      d[1] = 8'h12; req_last = 4'b0010;
      cyc("a_w1",   1'b1, 4'b0010, 2'd1, 1'b1, 8'h12);
      req = 4'b1000; req_last = 4'b0000;
      cyc("a_gap",  1'b0, 4'b0000, 2'd1, 1'b0, 8'h00);
      req_last = 4'b1000;
      cyc("a_r3",   1'b1, 4'b1000, 2'd3, 1'b1, 8'h31);
      req = 4'b0000; req_last = 4'b0000;
      cyc("a_hold", 1'b0, 4'b0000, 2'd3, 1'b0, 8'h00);

      // All four continuously requesting 2-word packets.
      for (int p = 0; p < 5; p++) begin
         int o;
         o = exp_order[p];
         req = 4'b1111; req_last = 4'b0000;
         cyc($sformatf("rr%0d_idle", p), 1'b0, 4'b0000, 2'(prev_gid[p]), 1'b0, 8'h00);
         d[o] = 8'(16 * p);
         cyc($sformatf("rr%0d_w0", p), 1'b1, 4'(1 << o), 2'(o), 1'b1, 8'(16 * p));
         d[o] = 8'(16 * p + 1); req_last = 4'(1 << o);
         cyc($sformatf("rr%0d_w1", p), 1'b1, 4'(1 << o), 2'(o), 1'b1, 8'(16 * p + 1));
      end

      // full held for three cycles mid-packet (rr_ptr=1).
      req = 4'b0010; req_last = 4'b0000;
      cyc("f_idle", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);
      d[1] = 8'hC0;
      cyc("f_w0", 1'b1, 4'b0010, 2'd1, 1'b1, 8'hC0);
      d[1] = 8'hC1;
      cyc("f_w1", 1'b1, 4'b0010, 2'd1, 1'b1, 8'hC1);
      d[1] = 8'hC2; full = 1'b1;
      for (int i = 0; i < 3; i++)
         cyc($sformatf("f_full%0d", i), 1'b0, 4'b0000, 2'd1, 1'b1, 8'h00);
      full = 1'b0;
      cyc("f_w2", 1'b1, 4'b0010, 2'd1, 1'b1, 8'hC2);
      d[1] = 8'hC3; req_last = 4'b0010;
      cyc("f_w3", 1'b1, 4'b0010, 2'd1, 1'b1, 8'hC3);

      // Owner 0 drops req for two cycles while requester 2 asks (rr_ptr=2).
      req = 4'b0001; req_last = 4'b0000;
      cyc("d_idle", 1'b0, 4'b0000, 2'd1, 1'b0, 8'h00);
      d[0] = 8'hD0;
      cyc("d_w0", 1'b1, 4'b0001, 2'd0, 1'b1, 8'hD0);
      req = 4'b0100;
      cyc("d_gap0", 1'b0, 4'b0000, 2'd0, 1'b1, 8'h00);
      cyc("d_gap1", 1'b0, 4'b0000, 2'd0, 1'b1, 8'h00);
      req = 4'b0101; d[0] = 8'hD1; req_last = 4'b0001;
      cyc("d_w1", 1'b1, 4'b0001, 2'd0, 1'b1, 8'hD1);

      // Requester 2 packet abandoned by reset after word 2 (rr_ptr=1 beforehand).
      req = 4'b0100; req_last = 4'b0000;
      cyc("e_idle", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);
      d[2] = 8'hE0;
      cyc("e_w0", 1'b1, 4'b0100, 2'd2, 1'b1, 8'hE0);
      d[2] = 8'hE1;
      cyc("e_w1", 1'b1, 4'b0100, 2'd2, 1'b1, 8'hE1);
      d[2] = 8'hE2; reset = 1'b1;
      next_cycle();
      reset = 1'b0; req = 4'b0101; d[0] = 8'hF0; req_last = 4'b0001;
      cyc("e_rst", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);
      cyc("e_rr0", 1'b1, 4'b0001, 2'd0, 1'b1, 8'hF0);

      // full rises on requester 3's last word; release then rr_ptr wraps to 0.
      req = 4'b1000; req_last = 4'b0000;
      cyc("g_idle", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);
      d[3] = 8'hA0;
      cyc("g_w0", 1'b1, 4'b1000, 2'd3, 1'b1, 8'hA0);
      d[3] = 8'hA1; req_last = 4'b1000; full = 1'b1;
      cyc("g_blk", 1'b0, 4'b0000, 2'd3, 1'b1, 8'h00);
      full = 1'b0;
      cyc("g_last", 1'b1, 4'b1000, 2'd3, 1'b1, 8'hA1);
      req = 4'b1111; req_last = 4'b0000; d[0] = 8'h5A;
      cyc("g_idle2", 1'b0, 4'b0000, 2'd3, 1'b0, 8'h00);
      cyc("g_wrap", 1'b1, 4'b0001, 2'd0, 1'b1, 8'h5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the width of each requester data word and of the FIFO write word.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (power of two, 2..8); ID_WIDTH = clog2(NUM_REQ).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req, input, NUM_REQ bits: per-requester word-valid.
REQ-006 The block SHALL have port req_last, input, NUM_REQ bits: per-requester end-of-packet flag, qualified by req.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: requester i owns bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port ack, output, NUM_REQ bits: one-hot pulse; word accepted from that requester this cycle.
REQ-009 The block SHALL have port full, input, 1 bit: downstream FIFO full flag.
REQ-010 The block SHALL have port wr, output, 1 bit: FIFO write strobe.
REQ-011 The block SHALL have port wr_data, output, DATA_WIDTH bits: FIFO write word.
REQ-012 The block SHALL have port grant_id, output, ID_WIDTH bits: index of the current owner.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a packet owns the FIFO (state LOCKED).

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and LOCKED.
REQ-015 In IDLE, no write SHALL occur; wr=0 and ack=0.
REQ-016 In IDLE with any req bit set, the block SHALL pick the first set req bit searching upward from rr_ptr, wrapping modulo NUM_REQ; it SHALL register that index into grant_id and enter LOCKED on the next edge.
REQ-017 In IDLE with req=0, state, grant_id and rr_ptr SHALL hold.
REQ-018 In LOCKED, the block SHALL drive wr = req[grant_id] & ~full, combinationally.
REQ-019 In LOCKED, ack[grant_id] SHALL equal wr; all other ack bits SHALL be 0.
REQ-020 wr_data SHALL equal the req_data slice of grant_id whenever wr=1 (don't-care otherwise).
REQ-021 When full=1, wr SHALL be 0; no word is lost, and the requester holds req and data until ack.
REQ-022 Requests from non-owners SHALL be ignored in LOCKED, with no ack and no state change.
REQ-023 In LOCKED, a cycle with wr=1 and req_last[grant_id]=1 SHALL end the packet: next state IDLE, rr_ptr <= (grant_id+1) mod NUM_REQ (wrap from NUM_REQ-1 to 0).
REQ-024 If req[grant_id] drops mid-packet, the block SHALL stay LOCKED with no writes until the owner resumes; the lock is not released without last.
REQ-025 A single-word packet (last on the first word) SHALL occupy exactly one LOCKED cycle when full=0.
REQ-026 Minimum latency SHALL be one cycle: req asserted in IDLE cycle N gives the first wr in cycle N+1, and back-to-back packets have one IDLE cycle between them.
REQ-027 full rising in the same cycle as the last word SHALL block the write, and the packet SHALL remain LOCKED until that write completes.

Reset
REQ-028 On reset=1 at a clock edge, the block SHALL set state IDLE, grant_id=0, rr_ptr=0 and busy=0; wr and ack are then 0.
REQ-029 Reset asserted mid-packet SHALL abandon the packet without finishing it; words already written remain in the FIFO.
REQ-030 Reset SHALL take priority over every other event in the same cycle.

Verification
REQ-031 The bench SHALL cover: after reset, req=4'b1010 -> grant_id=1; words written only from requester 1 until its last; then grant_id=3.
REQ-032 The bench SHALL cover: all four requesting 2-word packets continuously -> grant order 0,1,2,3,0; each packet 2 wr cycles plus 1 IDLE cycle.
REQ-033 The bench SHALL cover: full=1 for 3 cycles mid-packet -> wr=0 and ack=0 during those cycles; data order preserved; no dropped or duplicated word.
REQ-034 The bench SHALL cover: the owner deasserts req for 2 cycles mid-packet while requester 2 requests -> busy stays 1, grant_id is unchanged, requester 2 gets no ack.
REQ-035 The bench SHALL cover: reset pulsed during a 4-word packet after word 2 -> next cycle busy=0, wr=0; the next grant starts from rr_ptr=0.
REQ-036 The bench SHALL cover: full rises on the last word of requester 3 -> the write waits; on full=0, the last word is written and rr_ptr wraps to 0.
